// File: rtl/ex_fwd_ctrl.sv
// rtl/ex_fwd_ctrl.sv - EX-stage operand forwarding selects and load-use stall control
// Tracks MEM/WB destinations, registers per-operand forwarding decisions, counts stall cycles.
module ex_fwd_ctrl #(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic [REG_ADDR_W-1:0] ex_dst,
   input  logic                  ex_regwrite,
   input  logic                  ex_memread,
   output logic [1:0]            fwd_a_sel,
   output logic [1:0]            fwd_b_sel,
   output logic                  stall,
   output logic [REG_ADDR_W-1:0] mem_dst,
   output logic                  mem_regwrite,
   output logic [REG_ADDR_W-1:0] wb_dst,
   output logic                  wb_regwrite,
   output logic [CNT_W-1:0]      stall_cnt
);

   localparam logic [1:0] SEL_RF  = 2'b00;
   localparam logic [1:0] SEL_EXM = 2'b10;
   localparam logic [1:0] SEL_MWB = 2'b01;

   logic [1:0]            fwd_a_sel_q, fwd_a_sel_d;
   logic [1:0]            fwd_b_sel_q, fwd_b_sel_d;
   logic [REG_ADDR_W-1:0] mem_dst_q, mem_dst_d;
   logic                  mem_regwrite_q, mem_regwrite_d;
   logic [REG_ADDR_W-1:0] wb_dst_q, wb_dst_d;
   logic                  wb_regwrite_q, wb_regwrite_d;
   logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
   logic                  stall_c;
   logic [1:0]            dec_a, dec_b;

   function automatic logic [1:0] fwd_decide(
      input logic [REG_ADDR_W-1:0] src,
      input logic [REG_ADDR_W-1:0] e_dst,
      input logic                  e_rw,
      input logic [REG_ADDR_W-1:0] m_dst,
      input logic                  m_rw
   );
      logic [1:0] sel;
      sel = SEL_RF;
      // The EX-stage producer is the youngest write, so it wins over MEM.
      if (src != '0 && e_rw && e_dst == src) begin
         sel = SEL_EXM;
      end else if (src != '0 && m_rw && m_dst == src) begin
         sel = SEL_MWB;
      end
      return sel;
   endfunction

   always_comb begin
      stall_c = ex_memread && ex_regwrite && (ex_dst != '0) &&
                ((ex_dst == id_rs) || (ex_dst == id_rt));
      dec_a   = fwd_decide(id_rs, ex_dst, ex_regwrite, mem_dst_q, mem_regwrite_q);
      dec_b   = fwd_decide(id_rt, ex_dst, ex_regwrite, mem_dst_q, mem_regwrite_q);

      fwd_a_sel_d    = fwd_a_sel_q;
      fwd_b_sel_d    = fwd_b_sel_q;
      mem_dst_d      = mem_dst_q;
      mem_regwrite_d = mem_regwrite_q;
      wb_dst_d       = wb_dst_q;
      wb_regwrite_d  = wb_regwrite_q;
      stall_cnt_d    = stall_cnt_q;

      if (en) begin
         mem_dst_d      = ex_dst;
         mem_regwrite_d = ex_regwrite;
         wb_dst_d       = mem_dst_q;
         wb_regwrite_d  = mem_regwrite_q;
         // A stalled cycle sends a bubble into EX, which needs no forwarding.
         fwd_a_sel_d    = stall_c ? SEL_RF : dec_a;
         fwd_b_sel_d    = stall_c ? SEL_RF : dec_b;
         if (stall_c && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fwd_a_sel_q    <= SEL_RF;
         fwd_b_sel_q    <= SEL_RF;
         mem_dst_q      <= '0;
         mem_regwrite_q <= 1'b0;
         wb_dst_q       <= '0;
         wb_regwrite_q  <= 1'b0;
         stall_cnt_q    <= '0;
      end else begin
         fwd_a_sel_q    <= fwd_a_sel_d;
         fwd_b_sel_q    <= fwd_b_sel_d;
         mem_dst_q      <= mem_dst_d;
         mem_regwrite_q <= mem_regwrite_d;
         wb_dst_q       <= wb_dst_d;
         wb_regwrite_q  <= wb_regwrite_d;
         stall_cnt_q    <= stall_cnt_d;
      end
   end

   assign fwd_a_sel    = fwd_a_sel_q;
   assign fwd_b_sel    = fwd_b_sel_q;
   assign stall        = stall_c;
   assign mem_dst      = mem_dst_q;
   assign mem_regwrite = mem_regwrite_q;
   assign wb_dst       = wb_dst_q;
   assign wb_regwrite  = wb_regwrite_q;
   assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_ex_fwd_ctrl.sv
// tb/tb_ex_fwd_ctrl.sv - self-checking bench for ex_fwd_ctrl
module tb_ex_fwd_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b1;
   logic [4:0]  id_rs = '0, id_rt = '0, ex_dst = '0;
   logic        ex_regwrite = 1'b0, ex_memread = 1'b0;
   logic [1:0]  fwd_a_sel, fwd_b_sel;
   logic        stall;
   logic [4:0]  mem_dst, wb_dst;
   logic        mem_regwrite, wb_regwrite;
   logic [15:0] stall_cnt;

   ex_fwd_ctrl #(.REG_ADDR_W(5), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .en(en),
      .id_rs(id_rs), .id_rt(id_rt), .ex_dst(ex_dst),
      .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall),
      .mem_dst(mem_dst), .mem_regwrite(mem_regwrite),
      .wb_dst(wb_dst), .wb_regwrite(wb_regwrite), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [1:0]  a, b;
      logic [4:0]  md, wd;
      logic        mrw, wrw;
      logic [15:0] cnt;
   } exp_t;

   exp_t sb[$];

   int checks = 0;
   int failures = 0;

   logic [1:0]  m_a = '0, m_b = '0;
   logic [4:0]  m_md = '0, m_wd = '0;
   logic        m_mrw = 1'b0, m_wrw = 1'b0;
   logic [15:0] m_cnt = '0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
      end
   endtask

   function automatic logic [1:0] ref_sel(input logic [4:0] x);
      if (x != 0 && ex_regwrite && ex_dst == x) return 2'b10;
      if (x != 0 && m_mrw && m_md == x) return 2'b01;
      return 2'b00;
   endfunction

   task automatic model_reset();
      m_a = '0; m_b = '0; m_md = '0; m_wd = '0;
      m_mrw = 1'b0; m_wrw = 1'b0; m_cnt = '0;
   endtask

   task automatic step(input string tag, input bit quiet);
      logic es;
      exp_t e;
      es = ex_memread && ex_regwrite && ex_dst != 0 && (ex_dst == id_rs || ex_dst == id_rt);
      if (!quiet) chk({tag, ".stall"}, 32'(stall), 32'(es));
      if (en) begin
         m_a   = es ? 2'b00 : ref_sel(id_rs);
         m_b   = es ? 2'b00 : ref_sel(id_rt);
         m_wd  = m_md;
         m_wrw = m_mrw;
         m_md  = ex_dst;
         m_mrw = ex_regwrite;
         if (es && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
      e.tag = tag; e.a = m_a; e.b = m_b; e.md = m_md; e.mrw = m_mrw;
      e.wd = m_wd; e.wrw = m_wrw; e.cnt = m_cnt;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         chk({tag, ".sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         if (!quiet) begin
            chk({e.tag, ".fwd_a"}, 32'(fwd_a_sel), 32'(e.a));
            chk({e.tag, ".fwd_b"}, 32'(fwd_b_sel), 32'(e.b));
            chk({e.tag, ".mem_dst"}, 32'(mem_dst), 32'(e.md));
            chk({e.tag, ".mem_rw"}, 32'(mem_regwrite), 32'(e.mrw));
            chk({e.tag, ".wb_dst"}, 32'(wb_dst), 32'(e.wd));
            chk({e.tag, ".wb_rw"}, 32'(wb_regwrite), 32'(e.wrw));
            chk({e.tag, ".cnt"}, 32'(stall_cnt), 32'(e.cnt));
         end
      end
   endtask

   task automatic drive(input logic [4:0] dst, input logic rw, input logic mr,
                        input logic [4:0] rs, input logic [4:0] rt);
      ex_dst = dst; ex_regwrite = rw; ex_memread = mr; id_rs = rs; id_rt = rt;
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".fwd_a"}, 32'(fwd_a_sel), 32'd0);
      chk({tag, ".fwd_b"}, 32'(fwd_b_sel), 32'd0);
      chk({tag, ".mem_dst"}, 32'(mem_dst), 32'd0);
      chk({tag, ".mem_rw"}, 32'(mem_regwrite), 32'd0);
      chk({tag, ".wb_dst"}, 32'(wb_dst), 32'd0);
      chk({tag, ".wb_rw"}, 32'(wb_regwrite), 32'd0);
      chk({tag, ".cnt"}, 32'(stall_cnt), 32'd0);
   endtask

   initial begin
      #12;
      chk_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      drive(5'd8, 1'b1, 1'b0, 5'd8, 5'd9);
      step("exmem_fwd", 1'b0);

      drive(5'd5, 1'b1, 1'b0, 5'd0, 5'd0);
      step("memwb_p1", 1'b0);
      drive(5'd6, 1'b1, 1'b0, 5'd5, 5'd6);
      step("memwb_p2", 1'b0);
      drive(5'd5, 1'b1, 1'b0, 5'd1, 5'd2);
      step("prio_p1", 1'b0);
      drive(5'd5, 1'b1, 1'b0, 5'd5, 5'd0);
      step("prio_ex", 1'b0);

      drive(5'd10, 1'b1, 1'b1, 5'd3, 5'd10);
      step("loaduse", 1'b0);
      drive(5'd0, 1'b0, 1'b0, 5'd3, 5'd10);
      step("after_stall", 1'b0);

      drive(5'd0, 1'b1, 1'b1, 5'd0, 5'd0);
      step("zero_guard", 1'b0);

      drive(5'd12, 1'b1, 1'b1, 5'd12, 5'd4);
      en = 1'b0;
      for (int i = 0; i < 3; i++) step("freeze", 1'b0);
      en = 1'b1;
      step("unfreeze", 1'b0);

      while (m_cnt != 16'hFFFE) step("fill", 1'b1);
      step("sat_reach", 1'b0);
      step("sat_hold1", 1'b0);
      step("sat_hold2", 1'b0);

      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk_zero("async_reset");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      drive(5'd0, 1'b0, 1'b0, 5'd12, 5'd12);
      step("post_reset", 1'b0);

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
